// File: rtl/wam_hit_if.sv
// Player/mole-generator signal bundle for the whack-a-mole hit detector.
// master drives buttons, holes and enable; slave returns hit pulses and BCD counters.
interface wam_hit_if;
  logic [7:0] btn;
  logic [7:0] holes;
  logic       en;
  logic [7:0] hit;
  logic [7:0] score;
  logic [7:0] miss;

  modport master (
    output btn,
    output holes,
    output en,
    input  hit,
    input  score,
    input  miss
  );

  modport slave (
    input  btn,
    input  holes,
    input  en,
    output hit,
    output score,
    output miss
  );
endinterface

// File: rtl/wam_hit.sv
// Whack-a-mole hit detector: synchronizes and debounces eight buttons, pulses hit per
// whacked mole and keeps saturating two-digit BCD hit and miss counters.
module wam_hit #(
  parameter int unsigned DB_LEN = 3
) (
  input logic     clk_19,
  input logic     clr_n,
  wam_hit_if.slave bus
);

  logic [7:0]             sync1_q, sync2_q;
  logic [7:0][DB_LEN-1:0] sr_q, sr_d;
  logic [7:0]             db_q, db_d;
  logic [7:0]             press;
  logic [7:0]             hit_q, hit_d;
  logic [7:0]             miss_vec_q, miss_vec_d;
  logic [7:0]             score_q, score_d;
  logic [7:0]             miss_cnt_q, miss_cnt_d;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + 4'(v[i]);
    end
    return cnt;
  endfunction

  // Adds 0..8 to a two-digit BCD value, clamping at 99 instead of wrapping.
  function automatic logic [7:0] bcd_add_sat(input logic [7:0] v, input logic [3:0] n);
    logic [4:0] units;
    logic [3:0] tens;
    units = {1'b0, v[3:0]} + {1'b0, n};
    tens  = v[7:4];
    if (units > 5'd9) begin
      units = units - 5'd10;
      tens  = tens + 4'd1;
    end
    if (tens > 4'd9) begin
      return 8'h99;
    end
    return {tens, 4'(units)};
  endfunction

  always_comb begin
    sr_d  = sr_q;
    db_d  = db_q;
    press = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sr_d[i] = {sr_q[i][DB_LEN-2:0], sync2_q[i]};
      if (&sr_q[i]) begin
        db_d[i] = 1'b1;
      end else if (~|sr_q[i]) begin
        db_d[i] = 1'b0;
      end
      press[i] = (&sr_q[i]) & ~db_q[i];
    end
  end

  // holes is looked at only on the press edge, so a vanished mole cannot be hit.
  always_comb begin
    hit_d      = press & bus.holes & {8{bus.en}};
    miss_vec_d = press & ~bus.holes & {8{bus.en}};
    score_d    = bcd_add_sat(score_q, popcount(hit_q));
    miss_cnt_d = bcd_add_sat(miss_cnt_q, popcount(miss_vec_q));
  end

  always_ff @(posedge clk_19 or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
      sr_q       <= '0;
      db_q       <= 8'h00;
      hit_q      <= 8'h00;
      miss_vec_q <= 8'h00;
      score_q    <= 8'h00;
      miss_cnt_q <= 8'h00;
    end else begin
      sync1_q    <= bus.btn;
      sync2_q    <= sync1_q;
      sr_q       <= sr_d;
      db_q       <= db_d;
      hit_q      <= hit_d;
      miss_vec_q <= miss_vec_d;
      score_q    <= score_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.hit   = hit_q;
  assign bus.score = score_q;
  assign bus.miss  = miss_cnt_q;

endmodule

// File: doc/wam_hit.md
WAM_HIT -- requirements
Module: wam_hit

Interface
REQ-001 Parameter DB_LEN, default 3, number of consecutive equal synchronized samples required to change a debounced button level; legal range 2..8.
REQ-002 clk_19  input  1  game clock; all state updates on its rising edge.
REQ-003 clr_n  input  1  reset, asynchronous, active-low.
REQ-004 btn  input  8  raw player buttons, active-high, asynchronous to clk_19; bit i is hole i.
REQ-005 holes  input  8  mole-present vector from the mole generator, synchronous to clk_19; bit i high = mole in hole i.
REQ-006 en  input  1  game running; synchronous to clk_19.
REQ-007 hit  output  8  registered one-cycle pulse per hole when the player whacks a present mole; returned to the mole generator.
REQ-008 score  output  8  registered two-digit BCD hit count, [7:4] tens, [3:0] units.
REQ-009 miss  output  8  registered two-digit BCD count of presses on empty holes, same format as score.

Function
REQ-010 Each btn bit SHALL pass through a 2-flop synchronizer; the second flop feeds a DB_LEN-bit per-hole sample shift register.
REQ-011 The debounced level db[i] SHALL become 1 at the edge where the shift register is all ones, become 0 at the edge where it is all zeros, and hold otherwise.
REQ-012 A press event on hole i SHALL be a debounced rise: shift register all ones while db[i]=0; exactly one event per press, however long the button is held.
REQ-013 At the press-event edge, hit[i] SHALL be set to (holes[i] & en) and all other non-press bits of hit cleared; hit bits are high for exactly one cycle.
REQ-014 Latency: a btn[i] held high from its first sampling edge E yields hit[i] high in the cycle after edge E+2+DB_LEN (E+5 for DB_LEN=3).
REQ-015 A press event on hole i with holes[i]=0 and en=1 SHALL be a miss for that hole in the same cycle; presses while en=0 are neither hits nor misses.
REQ-016 One cycle after the press-event edge, score SHALL increase by the popcount of the registered hit vector (0..8), in BCD with carry from units to tens.
REQ-017 miss SHALL likewise increase by the popcount of the registered miss vector, in BCD, one cycle after the press-event edge.
REQ-018 score and miss SHALL saturate at 8'h99; an increment that would exceed 99 yields 99; no wrap.
REQ-019 Simultaneous press events on several holes SHALL all be reported in the same hit/miss vectors and counted in full.
REQ-020 A mole that disappears (holes[i] falls) before its press-event edge SHALL not produce a hit; holes is sampled only at the press-event edge.
REQ-021 Debounce and synchronizer state SHALL run regardless of en, so a button held across en rising does not generate a press event.
REQ-022 Bouncing input (toggling faster than DB_LEN consecutive equal samples) SHALL leave db unchanged and produce no events.

Reset
REQ-023 While clr_n=0: hit=8'h00, score=8'h00, miss=8'h00; synchronizers, shift registers, db and internal hit/miss registers all zero.
REQ-024 Reset assertion mid-press SHALL clear all state immediately; after release, a button still held high SHALL produce a new press event after the full REQ-014 latency.
REQ-025 Outputs SHALL change only on clk_19 edges after clr_n returns high.

Verification
REQ-026 Single hit: en=1, holes=8'h04, btn[2] high 10 cycles from edge E -> hit=8'h04 for one cycle after E+5; score=8'h01 one cycle later; miss=8'h00.
REQ-027 Miss and bounce: holes=8'h00, btn[5] toggles every cycle for 8 cycles then held high -> no event during toggling; one miss; miss=8'h01, hit stays 8'h00.
REQ-028 Multi-hit BCD carry: score preloaded to 8'h07 via 7 single hits; holes=8'hFF, btn=8'h0F held -> hit=8'h0F for one cycle, score=8'h11.
REQ-029 Saturation: drive score to 8'h97, then 8 simultaneous hits -> score=8'h99 and stays 8'h99 on further hits.
REQ-030 Gating: en=0 with holes=8'hFF, press btn[0] -> no hit, no score/miss change; en raised while btn[0] still held -> no event until released and pressed again.
REQ-031 Reset mid-operation: score=8'h23, miss=8'h05, btn[1] held; pulse clr_n low one cycle -> all outputs 8'h00 immediately; hit[1] (holes[1]=1) one cycle after the 6th edge following release.
